// File: rtl/cluster_clock_gate_ctrl.sv
// Idle-driven clock gate controller for a cluster clock gating cell.
// Drains before gating, settles after waking, counts gated cycles.
module cluster_clock_gate_ctrl #(
  parameter int IDLE_CYCLES = 8,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             test_en_i,
  input  logic             busy_i,
  input  logic             wake_req_i,
  input  logic             clr_i,
  output logic             wake_ack_o,
  output logic             en_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] gated_cnt_o
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    DRAIN = 2'b01,
    OFF   = 2'b10,
    WAKE  = 2'b11
  } state_t;

  localparam logic [7:0] IDLE_LD = 8'(IDLE_CYCLES - 1);
  localparam logic [7:0] WAKE_LD = 8'(WAKE_CYCLES - 1);

  state_t           state;
  logic [7:0]       cnt;
  logic             wake_ack;
  logic [CNT_W-1:0] gated_cnt;
  logic             req;

  assign req = busy_i | wake_req_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= RUN;
      cnt       <= '0;
      wake_ack  <= 1'b0;
      gated_cnt <= '0;
    end else begin
      wake_ack <= wake_req_i & (state == RUN);

      if (clr_i)
        gated_cnt <= '0;
      else if (state == OFF && gated_cnt != '1)
        gated_cnt <= gated_cnt + 1'b1;

      unique case (state)
        RUN: begin
          if (!req) begin
            state <= DRAIN;
            cnt   <= IDLE_LD;
          end
        end
        DRAIN: begin
          if (req)
            state <= RUN;
          else if (cnt == '0)
            state <= OFF;
          else
            cnt <= cnt - 1'b1;
        end
        OFF: begin
          if (req) begin
            state <= WAKE;
            cnt   <= WAKE_LD;
          end
        end
        WAKE: begin
          // Once started, a wake always runs to completion
          if (cnt == '0)
            state <= RUN;
          else
            cnt <= cnt - 1'b1;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign en_o        = (state != OFF) | test_en_i;
  assign state_o     = state;
  assign wake_ack_o  = wake_ack;
  assign gated_cnt_o = gated_cnt;

endmodule

// File: tb/tb_cluster_clock_gate_ctrl.sv
// Directed and randomized checks of cluster_clock_gate_ctrl
// against a cycle-level behavioural model.
module tb_cluster_clock_gate_ctrl;

  localparam int IDLE = 4;
  localparam int WK   = 2;
  localparam int CW   = 4;
  localparam int GMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          test_en = 1'b0;
  logic          busy = 1'b0;
  logic          wake_req = 1'b0;
  logic          clr = 1'b0;
  logic          wake_ack;
  logic          en;
  logic [1:0]    state;
  logic [CW-1:0] gcnt;

  int nvec = 0;
  int nerr = 0;

  // model: mode 0 run, 1 drain, 2 off, 3 wake; age = cycles spent in mode
  int m_mode = 0;
  int m_age  = 0;
  int m_ack  = 0;
  int m_gcnt = 0;

  cluster_clock_gate_ctrl #(
    .IDLE_CYCLES(IDLE),
    .WAKE_CYCLES(WK),
    .CNT_W(CW)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .test_en_i(test_en),
    .busy_i(busy),
    .wake_req_i(wake_req),
    .clr_i(clr),
    .wake_ack_o(wake_ack),
    .en_o(en),
    .state_o(state),
    .gated_cnt_o(gcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int req;
    req = busy | wake_req;
    if (!rst_n) begin
      m_mode = 0; m_age = 0; m_ack = 0; m_gcnt = 0;
    end else begin
      m_ack = (wake_req && m_mode == 0) ? 1 : 0;
      if (clr) m_gcnt = 0;
      else if (m_mode == 2 && m_gcnt < GMAX) m_gcnt++;
      case (m_mode)
        0: if (req == 0) begin m_mode = 1; m_age = 0; end
        1: if (req != 0) m_mode = 0;
           else if (m_age == IDLE - 1) m_mode = 2;
           else m_age++;
        2: if (req != 0) begin m_mode = 3; m_age = 0; end
        default: if (m_age == WK - 1) m_mode = 0;
                 else m_age++;
      endcase
    end
  endtask

  task automatic compare();
    chk("state", int'(state), m_mode);
    chk("en", int'(en), (m_mode != 2 || test_en) ? 1 : 0);
    chk("wake_ack", int'(wake_ack), m_ack);
    chk("gated_cnt", int'(gcnt), m_gcnt);
  endtask

  task automatic drive(input logic r, input logic b, input logic w,
                       input logic t, input logic c);
    rst_n = r; busy = b; wake_req = w; test_en = t; clr = c;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  initial begin
    @(negedge clk);
    // reset with arbitrary inputs
    drive(0, 1, 1, 0, 0); tick();
    drive(0, 0, 1, 1, 1); tick();
    chk("rst_state", int'(state), 0);
    chk("rst_en", int'(en), 1);
    chk("rst_ack", int'(wake_ack), 0);
    chk("rst_gcnt", int'(gcnt), 0);

    // gating: idle sampled from cycle 0
    drive(1, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i >= 1 && i <= 4) chk("gate_drain", int'(state), 1);
      if (i >= 5) begin
        chk("gate_off", int'(state), 2);
        chk("gate_en", int'(en), 0);
      end
      if (i == 8) chk("gate_cnt3", int'(gcnt), 3);
    end

    // wake sampled in OFF at t=8
    drive(1, 0, 1, 0, 0); tick();
    chk("wake_en_t1", int'(en), 1);
    tick(); tick();
    chk("wake_run_t3", int'(state), 0);
    tick();
    chk("wake_ack_t4", int'(wake_ack), 1);
    tick();
    drive(1, 0, 0, 0, 0); tick();
    chk("wake_ack_t6", int'(wake_ack), 0);
    chk("wake_drain_t6", int'(state), 1);
    chk("wake_gcnt", int'(gcnt), 4);

    // abort drain on the 3rd drain cycle
    drive(0, 0, 0, 0, 0); tick(); tick();
    drive(1, 0, 0, 0, 0); tick(); tick(); tick();
    drive(1, 1, 0, 0, 0); tick();
    chk("abort_run", int'(state), 0);
    chk("abort_gcnt", int'(gcnt), 0);
    tick();

    // test override while OFF
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) tick();
    chk("tovr_off", int'(state), 2);
    drive(1, 0, 0, 1, 0);
    #1;
    chk("tovr_en_same", int'(en), 1);
    tick(); tick();
    chk("tovr_state", int'(state), 2);
    chk("tovr_cnt", int'(gcnt), 3);

    // saturation and clear
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) tick();
    chk("sat", int'(gcnt), 15);
    drive(1, 0, 0, 0, 1); tick();
    chk("clr0", int'(gcnt), 0);
    drive(1, 0, 0, 0, 0); tick();
    chk("clr1", int'(gcnt), 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 49) != 0),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 29) == 0));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
